// File: rtl/bus_cycle_master.sv
// Master side of the multiplexed 8-bit address/data I/O-memory bus.
// Turns one req/ready request into a T1..T4 bus cycle followed by a one-cycle recovery (TR).
module bus_cycle_master #(
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        req,
    input  logic        we,
    input  logic [19:0] addr,
    input  logic [7:0]  wdata,
    output logic        ready,
    output logic        done,
    output logic [7:0]  rdata,
    output logic        CS,
    output logic        ALE,
    output logic        RD,
    output logic        WR,
    output logic [11:0] A,
    inout  wire  [7:0]  AD
);

    localparam int unsigned DW = 8;
    localparam int unsigned UW = 12;
    localparam int unsigned CW = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_T1,
        S_T2,
        S_T3,
        S_T4,
        S_TR
    } state_t;

    state_t        r_state;
    logic          r_we;
    logic [DW-1:0] r_wdata;
    logic [CW-1:0] r_wcnt;
    logic          r_ready;
    logic          r_done;
    logic [DW-1:0] r_rdata;
    logic          r_cs;
    logic          r_ale;
    logic          r_rd;
    logic          r_wr;
    logic [UW-1:0] r_a;
    logic          r_ad_oe;
    logic [DW-1:0] r_ad_out;

    assign ready = r_ready;
    assign done  = r_done;
    assign rdata = r_rdata;
    assign CS    = r_cs;
    assign ALE   = r_ale;
    assign RD    = r_rd;
    assign WR    = r_wr;
    assign A     = r_a;

    // AD is only driven from a register, so reset releases it immediately.
    assign AD = r_ad_oe ? r_ad_out : {DW{1'bz}};

    // Bus-cycle sequencer; every output is loaded together with the state it belongs to.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= S_IDLE;
            r_we     <= 1'b0;
            r_wdata  <= '0;
            r_wcnt   <= '0;
            r_ready  <= 1'b1;
            r_done   <= 1'b0;
            r_rdata  <= '0;
            r_cs     <= 1'b0;
            r_ale    <= 1'b0;
            r_rd     <= 1'b1;
            r_wr     <= 1'b1;
            r_a      <= '0;
            r_ad_oe  <= 1'b0;
            r_ad_out <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (req) begin
                        r_we     <= we;
                        r_wdata  <= wdata;
                        r_ready  <= 1'b0;
                        r_cs     <= 1'b1;
                        r_ale    <= 1'b1;
                        r_a      <= addr[19:8];
                        r_ad_oe  <= 1'b1;
                        r_ad_out <= addr[7:0];
                        r_state  <= S_T1;
                    end
                end
                S_T1: begin
                    // Strobe goes low in T2 so the slave leaves VALID at the end of T2.
                    r_ale   <= 1'b0;
                    r_rd    <= r_we;
                    r_wr    <= ~r_we;
                    r_wcnt  <= CW'(WAIT_STATES);
                    r_state <= S_T2;
                end
                S_T2: begin
                    if (r_we) begin
                        r_ad_out <= r_wdata;
                    end else begin
                        r_ad_oe  <= 1'b0;
                    end
                    r_state <= S_T3;
                end
                S_T3: begin
                    if (r_wcnt != '0) begin
                        r_wcnt <= r_wcnt - CW'(1);
                    end else begin
                        if (!r_we) begin
                            r_rdata <= AD;
                        end
                        r_rd    <= 1'b1;
                        r_wr    <= 1'b1;
                        r_state <= S_T4;
                    end
                end
                S_T4: begin
                    r_cs    <= 1'b0;
                    r_a     <= '0;
                    r_ad_oe <= 1'b0;
                    r_done  <= 1'b1;
                    r_state <= S_TR;
                end
                S_TR: begin
                    r_ready <= 1'b1;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_ready <= 1'b1;
                    r_cs    <= 1'b0;
                    r_ale   <= 1'b0;
                    r_rd    <= 1'b1;
                    r_wr    <= 1'b1;
                    r_ad_oe <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bus_cycle_master.sv
// Directed bench for bus_cycle_master: two masters (WAIT_STATES 0 and 3), each with a
// behavioural slave on its own AD bus.
module tb_bus_cycle_master;

    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    int   done_cnt0 = 0;

    always #5 clk = ~clk;

    logic        req0, we0, req1, we1;
    logic [19:0] addr0, addr1;
    logic [7:0]  wdata0, wdata1;
    logic        ready0, done0, cs0, ale0, rd0, wr0;
    logic        ready1, done1, cs1, ale1, rd1, wr1;
    logic [7:0]  rdata0, rdata1;
    logic [11:0] a0, a1;
    wire  [7:0]  ad0;
    wire  [7:0]  ad1;
    logic        probe0 = 1'b0;

    bus_cycle_master #(.WAIT_STATES(0)) u_dut0 (
        .clock(clk), .reset_n(rst_n), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
        .ready(ready0), .done(done0), .rdata(rdata0), .CS(cs0), .ALE(ale0), .RD(rd0),
        .WR(wr0), .A(a0), .AD(ad0)
    );

    bus_cycle_master #(.WAIT_STATES(3)) u_dut1 (
        .clock(clk), .reset_n(rst_n), .req(req1), .we(we1), .addr(addr1), .wdata(wdata1),
        .ready(ready1), .done(done1), .rdata(rdata1), .CS(cs1), .ALE(ale1), .RD(rd1),
        .WR(wr1), .A(a1), .AD(ad1)
    );

    typedef enum logic [2:0] {SL_IDLE, SL_VALID, SL_READ, SL_WRITE, SL_UPDATE} sl_t;
    sl_t         sl0, sl1;
    logic [19:0] sl0_addr, sl1_addr;
    logic [7:0]  sl0_q, sl1_q;
    logic [7:0]  mem0 [0:1048575];

    // Slave on bus 0: IDLE->VALID->READ/WRITE->UPDATE->IDLE, full 1 MB memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sl0      <= SL_IDLE;
            sl0_addr <= '0;
            sl0_q    <= '0;
        end else begin
            case (sl0)
                SL_IDLE:  if (cs0 && ale0) begin sl0 <= SL_VALID; sl0_addr <= {a0, ad0}; end
                SL_VALID: if (!rd0) begin sl0 <= SL_READ; sl0_q <= mem0[sl0_addr]; end
                          else if (!wr0) sl0 <= SL_WRITE;
                SL_READ:  if (rd0) sl0 <= SL_UPDATE;
                SL_WRITE: if (wr0) begin mem0[sl0_addr] <= ad0; sl0 <= SL_UPDATE; end
                default:  sl0 <= SL_IDLE;
            endcase
        end
    end

    // The probe drives a known pattern so a released AD can be told apart from a driven one.
    assign ad0 = (sl0 == SL_READ) ? sl0_q : (probe0 ? 8'hA0 : 8'hzz);

    // Slave on bus 1: read-only, location 0x00010 holds 0x77.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sl1      <= SL_IDLE;
            sl1_addr <= '0;
            sl1_q    <= '0;
        end else begin
            case (sl1)
                SL_IDLE:  if (cs1 && ale1) begin sl1 <= SL_VALID; sl1_addr <= {a1, ad1}; end
                SL_VALID: if (!rd1) begin
                              sl1   <= SL_READ;
                              sl1_q <= (sl1_addr == 20'h00010) ? 8'h77 : 8'h00;
                          end else if (!wr1) sl1 <= SL_WRITE;
                SL_READ:  if (rd1) sl1 <= SL_UPDATE;
                SL_WRITE: if (wr1) sl1 <= SL_UPDATE;
                default:  sl1 <= SL_IDLE;
            endcase
        end
    end

    assign ad1 = (sl1 == SL_READ) ? sl1_q : 8'hzz;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // Bus rules watched every cycle: no strobe overlap, ALE apart from strobes, no AD contention.
    always @(negedge clk) begin
        if (rst_n) begin
            chk("rd_wr_overlap0", 32'(rd0 | wr0), 32'd1);
            chk("ale_vs_strobe0", 32'(ale0 & ~(rd0 & wr0)), 32'd0);
            if (sl0 == SL_READ) chk("ad_contention0", 32'(ad0), 32'(sl0_q));
            if (sl1 == SL_READ) chk("ad_contention1", 32'(ad1), 32'(sl1_q));
            if (done0) done_cnt0++;
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog expired before end of stimulus");
        $fatal(1, "timeout");
    end

    initial begin
        int ale_cnt, ale_first, ale_second, dstart, rd_low, done_n, done_c;
        rst_n = 1'b0;
        req0 = 1'b0; we0 = 1'b0; addr0 = '0; wdata0 = '0;
        req1 = 1'b0; we1 = 1'b0; addr1 = '0; wdata1 = '0;
        repeat (2) cyc();
        chk("rst_cs", 32'(cs0), 32'd0);
        chk("rst_rd_wr", 32'({rd0, wr0}), 32'd3);
        chk("rst_ale", 32'(ale0), 32'd0);
        chk("rst_rdata", 32'(rdata0), 32'd0);
        chk("rst_done", 32'(done0), 32'd0);
        rst_n = 1'b1;
        cyc();
        chk("rel_ready", 32'(ready0), 32'd1);
        chk("rel_a", 32'(a0), 32'd0);

        // Reset in the middle of T3 of a write
        req0 = 1'b1; we0 = 1'b1; addr0 = 20'h12345; wdata0 = 8'h99;
        cyc(); req0 = 1'b0;
        cyc();
        cyc();
        chk("t1_pre_ad", 32'(ad0), 32'h99);
        chk("t1_pre_wr", 32'(wr0), 32'd0);
        rst_n = 1'b0; probe0 = 1'b1;
        #1;
        chk("t1_cs", 32'(cs0), 32'd0);
        chk("t1_rd_wr", 32'({rd0, wr0}), 32'd3);
        chk("t1_ale", 32'(ale0), 32'd0);
        chk("t1_ad_released", 32'(ad0), 32'hA0);
        repeat (3) cyc();
        rst_n = 1'b1; probe0 = 1'b0;
        cyc();
        chk("t1_ready", 32'(ready0), 32'd1);
        chk("t1_idle_cs", 32'(cs0), 32'd0);

        // Write 0x5E to 0xA53C1
        req0 = 1'b1; we0 = 1'b1; addr0 = 20'hA53C1; wdata0 = 8'h5E;
        cyc(); req0 = 1'b0;
        chk("w_T1_ale", 32'(ale0), 32'd1);
        chk("w_T1_cs", 32'(cs0), 32'd1);
        chk("w_T1_a", 32'(a0), 32'hA53);
        chk("w_T1_ad", 32'(ad0), 32'hC1);
        chk("w_T1_ready", 32'(ready0), 32'd0);
        cyc();
        chk("w_T2_ale", 32'(ale0), 32'd0);
        chk("w_T2_wr", 32'(wr0), 32'd0);
        chk("w_T2_ad", 32'(ad0), 32'hC1);
        cyc();
        chk("w_T3_ad", 32'(ad0), 32'h5E);
        chk("w_T3_wr", 32'(wr0), 32'd0);
        cyc();
        chk("w_T4_ad", 32'(ad0), 32'h5E);
        chk("w_T4_strobes", 32'({cs0, rd0, wr0}), 32'd7);
        chk("w_T4_done", 32'(done0), 32'd0);
        cyc();
        chk("w_TR_done", 32'(done0), 32'd1);
        chk("w_TR_cs_a", 32'({cs0, a0}), 32'd0);
        probe0 = 1'b1; #1;
        chk("w_TR_ad_released", 32'(ad0), 32'hA0);
        probe0 = 1'b0;
        chk("w_mem", 32'(mem0[20'hA53C1]), 32'h5E);
        cyc();
        chk("w_idle_done", 32'(done0), 32'd0);
        chk("w_idle_ready", 32'(ready0), 32'd1);

        // Read back 0xA53C1
        req0 = 1'b1; we0 = 1'b0; addr0 = 20'hA53C1;
        cyc(); req0 = 1'b0;
        chk("r_T1_ad", 32'(ad0), 32'hC1);
        cyc();
        chk("r_T2_rd", 32'({rd0, wr0}), 32'd1);
        chk("r_T2_ad", 32'(ad0), 32'hC1);
        cyc();
        chk("r_T3_rd", 32'(rd0), 32'd0);
        chk("r_T3_ad", 32'(ad0), 32'h5E);
        cyc();
        chk("r_T4_rd", 32'(rd0), 32'd1);
        chk("r_T4_cs", 32'(cs0), 32'd1);
        cyc();
        chk("r_TR_done", 32'(done0), 32'd1);
        chk("r_TR_rdata", 32'(rdata0), 32'h5E);
        cyc();

        // Back-to-back write then read with req held high
        req0 = 1'b1; we0 = 1'b1; addr0 = 20'h00001; wdata0 = 8'h11;
        ale_cnt = 0; ale_first = 0; ale_second = 0;
        for (int c = 1; c <= 11; c++) begin
            cyc();
            if (c == 1) we0 = 1'b0;
            if (c == 7) req0 = 1'b0;
            if (ale0) begin
                ale_cnt++;
                if (ale_first == 0) ale_first = c; else ale_second = c;
            end
            if (c == 6) chk("b2b_idle_ready", 32'(ready0), 32'd1);
            if (c == 11) begin
                chk("b2b_done", 32'(done0), 32'd1);
                chk("b2b_rdata", 32'(rdata0), 32'h11);
            end
        end
        chk("b2b_ale_first", 32'(ale_first), 32'd1);
        chk("b2b_ale_spacing", 32'(ale_second - ale_first), 32'd6);
        chk("b2b_ale_count", 32'(ale_cnt), 32'd2);
        cyc();

        // req pulsed while busy must be ignored
        dstart = done_cnt0;
        req0 = 1'b1; we0 = 1'b1; addr0 = 20'h00020; wdata0 = 8'h33;
        cyc(); req0 = 1'b0;
        chk("ign_T1_ale", 32'(ale0), 32'd1);
        cyc();
        req0 = 1'b1; we0 = 1'b0; addr0 = 20'h00099;
        cyc(); req0 = 1'b0;
        ale_cnt = 0;
        for (int c = 0; c < 5; c++) begin
            cyc();
            if (ale0) ale_cnt++;
        end
        chk("ign_no_ale", 32'(ale_cnt), 32'd0);
        chk("ign_done_count", 32'(done_cnt0 - dstart), 32'd1);
        chk("ign_mem", 32'(mem0[20'h00020]), 32'h33);

        // WAIT_STATES=3 read of 0x00010
        req1 = 1'b1; we1 = 1'b0; addr1 = 20'h00010;
        rd_low = 0; done_n = 0; done_c = 0;
        for (int c = 1; c <= 10; c++) begin
            cyc();
            if (c == 1) begin
                req1 = 1'b0;
                chk("ws_T1_ale", 32'(ale1), 32'd1);
            end
            if (!rd1) rd_low++;
            if (done1) begin
                done_n++;
                done_c = c;
                chk("ws_rdata", 32'(rdata1), 32'h77);
            end
        end
        chk("ws_rd_low_cycles", 32'(rd_low), 32'd5);
        chk("ws_done_cycle", 32'(done_c), 32'd8);
        chk("ws_done_pulses", 32'(done_n), 32'd1);
        chk("ws_rdata_hold", 32'(rdata1), 32'h77);

        repeat (2) cyc();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
